// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enemy_pkg
// Description : Shared state encoding and phase indices for the enemy frame
//               scheduler, the enemies datapath and top-level game control.
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_pkg;

  // Scheduler state encoding (3-bit)
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_GEN   = 3'd2,
    S_APPLY = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  // Bit positions of the one-hot phase vector
  localparam int PH_INIT    = 0;
  localparam int PH_IDLE    = 1;
  localparam int PH_GEN     = 2;
  localparam int PH_APPLY   = 3;
  localparam int PH_DRAW    = 4;
  localparam int NUM_PHASES = 5;

  // One-hot phase vector for a given state
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input state_t s);
    logic [NUM_PHASES-1:0] v;
    v = '0;
    case (s)
      S_INIT:  v[PH_INIT]  = 1'b1;
      S_IDLE:  v[PH_IDLE]  = 1'b1;
      S_GEN:   v[PH_GEN]   = 1'b1;
      S_APPLY: v[PH_APPLY] = 1'b1;
      S_DRAW:  v[PH_DRAW]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : enemy_frame_scheduler_if
// Description : Phase/completion bundle between the frame scheduler (master)
//               and the enemies datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface enemy_frame_scheduler_if;
  logic init;
  logic idle;
  logic gen_move;
  logic apply_move;
  logic draw;
  logic draw_done;

  modport master (
    output init, idle, gen_move, apply_move, draw,
    input  draw_done
  );

  modport slave (
    input  init, idle, gen_move, apply_move, draw,
    output draw_done
  );
endinterface
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_gen
// Description : Free-running frame counter; tick is high while the counter
//               sits on its last value.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  wire logic clock,
  input  wire logic reset,
  output logic      tick
);

  localparam int             CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count 0..FRAME_CYCLES-1 and wrap, independent of scheduler state
  always_ff @(posedge clock) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CNT_W'(1);
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/enemy_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : enemy_frame_scheduler
// Description : Turns the frame tick into one GEN/APPLY/DRAW pass per frame,
//               with a draw watchdog, pending-tick and overrun tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_frame_scheduler
  import enemy_pkg::*;
#(
  parameter int FRAME_CYCLES = 833333,
  parameter int INIT_CYCLES  = 4,
  parameter int DRAW_TIMEOUT = 2048
) (
  input  wire logic                clock,
  input  wire logic                reset,
  input  wire logic                enable,
  enemy_frame_scheduler_if.master  bus,
  output logic                     frame_overrun,
  output logic                     draw_timeout,
  output logic [7:0]               frame_count
);

  localparam int               IC_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IC_W-1:0]  INIT_LAST = IC_W'(INIT_CYCLES - 1);
  localparam int               WD_W      = $clog2(DRAW_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(DRAW_TIMEOUT - 1);

  state_t                  state, state_next;
  logic [NUM_PHASES-1:0]   phase;
  logic [IC_W-1:0]         init_cnt;
  logic [WD_W-1:0]         watchdog;
  logic                    pending;
  logic                    tick;
  logic                    start;
  logic                    draw_abort;

  frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Next-state decode; start/draw_abort are the pass-begin and watchdog events
  always_comb begin
    state_next = state;
    start      = 1'b0;
    draw_abort = 1'b0;
    case (state)
      S_INIT: begin
        // Counting only while init is visible keeps the reset cycle out of INIT_CYCLES
        if (phase[PH_INIT] && (init_cnt == INIT_LAST)) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (enable && (tick || pending)) begin
          state_next = S_GEN;
          start      = 1'b1;
        end
      end
      S_GEN:   state_next = S_APPLY;
      S_APPLY: state_next = S_DRAW;
      S_DRAW: begin
        if (bus.draw_done) begin
          state_next = S_IDLE;
        end else if (watchdog == WD_LAST) begin
          state_next = S_IDLE;
          draw_abort = 1'b1;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // State register and registered one-hot phase outputs (all low during reset)
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_INIT;
      phase    <= '0;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      phase <= phase_onehot(state_next);
      if (phase[PH_INIT]) init_cnt <= init_cnt + IC_W'(1);
    end
  end

  // Draw watchdog: cleared entering APPLY, counts every DRAW cycle
  always_ff @(posedge clock) begin
    if (reset)                       watchdog <= '0;
    else if (state_next == S_APPLY)  watchdog <= '0;
    else if (state == S_DRAW)        watchdog <= watchdog + WD_W'(1);
  end

  // Pending tick and overrun pulse: one tick may wait, a second is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= 1'b0;
      if (start) begin
        pending <= 1'b0;
      end else if (tick) begin
        if (pending) frame_overrun <= 1'b1;
        else         pending       <= 1'b1;
      end
    end
  end

  // Pass counter and sticky draw-abort flag
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count  <= 8'd0;
      draw_timeout <= 1'b0;
    end else begin
      if (start)      frame_count  <= frame_count + 8'd1;
      if (draw_abort) draw_timeout <= 1'b1;
    end
  end

  assign bus.init       = phase[PH_INIT];
  assign bus.idle       = phase[PH_IDLE];
  assign bus.gen_move   = phase[PH_GEN];
  assign bus.apply_move = phase[PH_APPLY];
  assign bus.draw       = phase[PH_DRAW];

endmodule
`default_nettype wire
